punc_fetch_unit: RTL and testbench
==================================

# punc_fetch_unit

Instruction fetch front end for the PUnC LC3 processor. It sits directly upstream of the PUnC control unit. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. It buffers returned instructions in a small queue and presents them to the control unit on a valid/ready interface. Redirects (BR/JMP/JSR/RET) and HALT from the control unit flush or stop the front end.

## Interface
- `ADDR_W`, 16: instruction address width.
- `DATA_W`, 16: instruction word width.
- `QDEPTH`, 2: queue depth when prefetch is enabled. Legal values are 1 or 2.
- `RESET_PC`, 16'h0000: first fetch address after reset.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_req` out 1: read request, registered.
- `mem_addr` out ADDR_W: read address, registered, stable while `mem_req` is high.
- `mem_ack` in 1: request accepted; `mem_rdata` valid this cycle.
- `mem_rdata` in DATA_W: instruction word.
- `ir_valid` out 1: queue head valid.
- `ir_data` out DATA_W: queue head instruction.
- `ir_pc` out ADDR_W: incremented PC of head instruction, i.e. fetch address + 1, mod 2^ADDR_W.
- `ir_ready` in 1: control unit consumes head.
- `redir_valid` in 1: one-cycle redirect pulse.
- `redir_pc` in ADDR_W: redirect target.
- `halt` in 1: HALT decoded; sticky effect until reset.
- `fetch_pc` out ADDR_W: next address to be requested (debug).

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DRAIN: outstanding request is stale and its data will be discarded.
  - HALTED.
- Issue rule: leave IDLE for REQ when (queue count + outstanding) < effective depth. The new request drives `mem_addr` = `fetch_pc`, and `fetch_pc` increments at issue.
- REQ holds `mem_req`/`mem_addr` until `mem_ack`. On ack, the data plus `ir_pc` = addr+1 is pushed into the queue. Next state is REQ again (new address) if space remains after this cycle's push/pop, else IDLE.
- Pop occurs when `ir_valid && ir_ready`. Push and pop in the same cycle are both honoured.
- Redirect (not HALTED):
  - Flush the queue and set `fetch_pc` = `redir_pc`.
  - If a request is outstanding without ack this cycle, go to DRAIN. A request is never withdrawn: `mem_req`/`mem_addr` stay until ack, then the data is dropped and the state returns to IDLE/REQ for `redir_pc`.
  - If a redirect coincides with `mem_ack`, the ack data is dropped and no DRAIN is needed.
  - A redirect takes priority over a same-cycle pop and push.
- Halt:
  - Enter HALTED; no new requests are issued.
  - An outstanding request still completes its handshake, and its data is dropped.
  - `ir_valid` is forced to 0 and the queue is flushed.
  - Redirects are ignored. Only `rst` exits HALTED.
- Wrap-around: `fetch_pc` 16'hFFFF increments to 16'h0000. `ir_pc` for address 16'hFFFF is 16'h0000.
- Reset mid-transaction clears all state immediately. Memory must tolerate `mem_req` dropping.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`.
  - `ir_valid`=0, `ir_data`=0, `ir_pc`=0.
  - State is IDLE.
- The first cycle after reset deassertion decides to issue, so `mem_req`=1 with `mem_addr`=`RESET_PC` in the second cycle.
- Ack in cycle N means the instruction appears on `ir_valid`/`ir_data` in cycle N+1.
- With zero-wait memory (ack the same cycle as `mem_req`) and `ir_ready` held high, throughput is one instruction per cycle with prefetch enabled.
- After a redirect in cycle N with nothing outstanding, `mem_req` with `redir_pc` appears in cycle N+1.

## Configuration
- `PUNC_FETCH_PREFETCH_EN` defined: effective depth = `QDEPTH`, and requests may overlap queue occupancy as above.
- Undefined: effective depth forced to 1. A request is issued only when the queue is empty and nothing is outstanding, so there is at most one instruction in flight or buffered. Throughput is at most one instruction per 2 cycles with zero-wait memory.

## Structure
- `punc_pkg`: fetch state enum (IDLE, REQ, DRAIN, HALTED), `ADDR_W`/`DATA_W` defaults, `RESET_PC` default.
- Sub-module `punc_fetch_queue`: parameterised 1–2 entry FIFO of {instr, pc}. It provides push/pop/flush, count, and head outputs.
- The top level holds the FSM, `fetch_pc`, and the outstanding flag.

## Test plan
- Reset, zero-wait memory returning 16'h1234 at 0 and 16'h5678 at 1, `ir_ready`=1:
  - `mem_req` high in cycle 2 with addr 0.
  - `ir_data`=16'h1234, `ir_pc`=1, then 16'h5678, `ir_pc`=2, on consecutive cycles (macro defined).
- `ir_ready`=0, memory always acks:
  - Exactly 2 requests are issued (addr 0, 1), then `mem_req`=0.
  - Raising `ir_ready` drains both and resumes at addr 2.
- Memory ack delayed 3 cycles on addr 4, redirect to 16'h3000 in the cycle after the request:
  - `mem_addr` stays 4 until ack, and that data never appears on `ir_valid`.
  - The next request is 16'h3000.
- Redirect to 16'h0010 in the same cycle as an ack for addr 7:
  - The addr-7 data is dropped.
  - The next cycle shows `mem_req` with addr 16'h0010.
- `fetch_pc` set to 16'hFFFF via redirect:
  - The instruction there yields `ir_pc`=16'h0000.
  - The next request is addr 16'h0000.
- `halt` pulse with one request outstanding:
  - The handshake completes, `ir_valid` stays 0, and no further `mem_req` occurs.
  - Redirects are ignored until `rst`.

Source files
------------

// File: rtl/punc_pkg.sv
// punc_pkg: shared definitions for the PUnC instruction fetch front end.
// Holds the fetch FSM state encoding and the default widths / reset PC.
package punc_pkg;

    localparam int              PUNC_ADDR_W   = 16;
    localparam int              PUNC_DATA_W   = 16;
    localparam logic [15:0]     PUNC_RESET_PC = 16'h0000;

    // IDLE: nothing outstanding; REQ: live request outstanding;
    // DRAIN: outstanding request is stale and its data is discarded;
    // HALTED: front end stopped until reset.
    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_REQ    = 2'd1,
        FETCH_DRAIN  = 2'd2,
        FETCH_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/punc_fetch_queue.sv
// punc_fetch_queue: 1-2 entry FIFO of {instruction, incremented pc}.
// Entry 0 is always the head, so the head outputs come straight from flops.
// Flush has priority over push and pop; push and pop in one cycle both apply.
module punc_fetch_queue
    import punc_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = PUNC_DATA_W,
    parameter int ADDR_W = PUNC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [ADDR_W-1:0] pc_d    [DEPTH];
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [1:0]        count_pop_s;
    logic              pop_en_s;
    logic              push_en_s;

    // Next-state: shift toward the head on pop, then write the push slot.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pop_en_s    = pop_i && (count_q != 2'd0);
        count_pop_s = pop_en_s ? (count_q - 2'd1) : count_q;
        push_en_s   = push_i && (count_pop_s < DEPTH_L);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop_en_s) begin
                instr_d[i] = instr_q[i+1];
                pc_d[i]    = pc_q[i+1];
            end else begin
                instr_d[i] = instr_q[i];
                pc_d[i]    = pc_q[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = (push_en_s && (count_pop_s == 2'(i))) ? push_instr_i : instr_d[i];
            pc_d[i]    = (push_en_s && (count_pop_s == 2'(i))) ? push_pc_i    : pc_d[i];
        end
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_pop_s + {1'b0, push_en_s};
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= {DATA_W{1'b0}};
                pc_q[i]    <= {ADDR_W{1'b0}};
            end
        end else begin
            count_q <= count_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_instr_o = instr_q[0];
    assign head_pc_o    = pc_q[0];

endmodule

// File: rtl/punc_fetch_unit.sv
// punc_fetch_unit: PUnC LC3 instruction fetch front end.
// Owns the fetch PC, issues word reads over req/ack, buffers returned words
// and hands them to the control unit on valid/ready. Redirects flush; HALT
// stops fetching until reset. Requests are never withdrawn once raised.
// Build option: define PUNC_FETCH_PREFETCH_EN to let requests overlap queue
// occupancy up to QDEPTH entries; otherwise only one instruction is ever
// in flight or buffered.
module punc_fetch_unit
    import punc_pkg::*;
#(
    parameter int              ADDR_W   = PUNC_ADDR_W,
    parameter int              DATA_W   = PUNC_DATA_W,
    parameter int              QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PUNC_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] fetch_pc
);

`ifdef PUNC_FETCH_PREFETCH_EN
    localparam int EFF_DEPTH = QDEPTH;
`else
    // Without prefetch the depth is capped at a single entry.
    localparam int EFF_DEPTH = (QDEPTH < 1) ? QDEPTH : 1;
`endif
    localparam logic [1:0] DEPTH_L = 2'(EFF_DEPTH);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              ack_s;
    logic              q_push_s, q_pop_s, q_flush_s, q_valid_s;
    logic [1:0]        q_count_s, count_pop_s;
    logic [DATA_W-1:0] q_instr_s;
    logic [ADDR_W-1:0] q_pc_s;

    punc_fetch_queue #(
        .DEPTH  (EFF_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (q_push_s),
        .push_instr_i (mem_rdata),
        .push_pc_i    (mem_addr_q + ADDR_W'(1)),
        .pop_i        (q_pop_s),
        .flush_i      (q_flush_s),
        .count_o      (q_count_s),
        .head_valid_o (q_valid_s),
        .head_instr_o (q_instr_s),
        .head_pc_o    (q_pc_s)
    );

    // Next-state: halt beats redirect beats normal fetch flow.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        ack_s       = mem_req_q && mem_ack;
        q_pop_s     = q_valid_s && ir_ready;
        q_push_s    = 1'b0;
        q_flush_s   = 1'b0;
        count_pop_s = q_pop_s ? (q_count_s - 2'd1) : q_count_s;
        if ((state_q == FETCH_HALTED) || halt) begin
            // Let an outstanding request finish its handshake, drop its data.
            state_d   = FETCH_HALTED;
            q_flush_s = 1'b1;
            q_pop_s   = 1'b0;
            if (ack_s) begin
                mem_req_d = 1'b0;
            end else begin
                mem_req_d = mem_req_q;
            end
        end else if (redir_valid) begin
            q_flush_s = 1'b1;
            q_pop_s   = 1'b0;
            if (mem_req_q && !mem_ack) begin
                // Request stays up until acked; its data will be dropped.
                state_d    = FETCH_DRAIN;
                fetch_pc_d = redir_pc;
            end else begin
                state_d    = FETCH_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = redir_pc;
                fetch_pc_d = redir_pc + ADDR_W'(1);
            end
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (count_pop_s < DEPTH_L) begin
                        state_d    = FETCH_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        mem_req_d  = 1'b0;
                    end
                end
                FETCH_REQ: begin
                    if (ack_s) begin
                        q_push_s = 1'b1;
                        if ((count_pop_s + 2'd1) < DEPTH_L) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        end else begin
                            state_d   = FETCH_IDLE;
                            mem_req_d = 1'b0;
                        end
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
                FETCH_DRAIN: begin
                    if (ack_s) begin
                        state_d    = FETCH_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = FETCH_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, request outputs and fetch PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign fetch_pc = fetch_pc_q;
    assign ir_valid = q_valid_s;
    assign ir_data  = q_instr_s;
    assign ir_pc    = q_pc_s;

endmodule

// File: tb/tb_punc_fetch_unit.sv
// tb_punc_fetch_unit: directed scenarios plus a randomized run for
// punc_fetch_unit. A transaction-level model tracks the expected instruction
// stream and request address sequence from the architectural rules.
module tb_punc_fetch_unit;

`ifdef PUNC_FETCH_PREFETCH_EN
    localparam int EFF = 2;
`else
    localparam int EFF = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_rdata;
    logic        ir_valid, ir_ready;
    logic [15:0] ir_data, ir_pc;
    logic        redir_valid, halt;
    logic [15:0] redir_pc, fetch_pc;

    always #5 clk = ~clk;

    punc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt        (halt),
        .fetch_pc    (fetch_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder state
    bit          busy;
    int          wait_cnt;
    int          base_delay;
    bit          rand_delay;
    bit          special_en;
    logic [15:0] special_addr;
    int          special_delay;

    // reference model state
    logic [15:0] exp_pc, exp_req;
    bit          halted_m;
    bit          prev_req, prev_ack, pre_redir_issue, new_req;
    logic [15:0] prev_addr;
    int          req_count, cons_count, ack_count;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        else if (a == 16'h0001) return 16'h5678;
        else return a ^ 16'hC3A5;
    endfunction

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task respond();
        if (mem_req === 1'b1) begin
            if (!busy) begin
                busy = 1'b1;
                if (special_en && mem_addr == special_addr) begin
                    wait_cnt   = special_delay;
                    special_en = 1'b0;
                end else if (rand_delay) begin
                    wait_cnt = int'($urandom_range(3, 0));
                end else begin
                    wait_cnt = base_delay;
                end
            end
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                busy      = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'(($urandom));
                wait_cnt--;
            end
        end else begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end
    endtask

    task tick();
        logic [15:0] nxt;
        pre_redir_issue = 1'b0;
        if (!rst && !halted_m) begin
            if (halt) begin
                halted_m = 1'b1;
            end else if (redir_valid) begin
                exp_pc          = redir_pc;
                exp_req         = redir_pc;
                pre_redir_issue = !mem_req || mem_ack;
            end else if (ir_valid && ir_ready) begin
                nxt = exp_pc + 16'd1;
                check("cons_data", ir_data, mem_word(exp_pc));
                check("cons_pc", ir_pc, nxt);
                exp_pc = nxt;
                cons_count++;
            end
        end
        if (mem_req && mem_ack) ack_count++;
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        @(posedge clk);
        #1;
        new_req = mem_req && !(prev_req && !prev_ack);
        if (!rst) begin
            if (prev_req && !prev_ack) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, prev_addr);
            end
            if (halted_m) begin
                check("halt_no_req", new_req, 0);
                check("halt_ir_valid", ir_valid, 0);
            end else if (new_req) begin
                check("req_addr", mem_addr, exp_req);
                exp_req = exp_req + 16'd1;
                req_count++;
            end
            if (pre_redir_issue) check("redir_latency", new_req, 1);
        end
        respond();
    endtask

    task do_reset();
        rst         = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        ir_ready    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        halt        = 1'b0;
        busy        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_pc     = 16'h0000;
        exp_req    = 16'h0000;
        halted_m   = 1'b0;
        req_count  = 0;
        cons_count = 0;
        ack_count  = 0;
        respond();
    endtask

    initial begin
        int          gap;
        int          c0;
        bit          found, got_req, got_ir;
        logic [15:0] req_addr_s, ir_pc_s, ir_data_s;

        base_delay    = 0;
        rand_delay    = 1'b0;
        special_en    = 1'b0;
        special_addr  = 16'h0000;
        special_delay = 0;

        // 1: reset values, first request, zero-wait stream
        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_fetch_pc", fetch_pc, 16'h0000);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_ir_data", ir_data, 16'h0000);
        check("rst_ir_pc", ir_pc, 16'h0000);
        ir_ready = 1'b1;
        tick();
        check("c2_mem_req", mem_req, 1);
        check("c2_mem_addr", mem_addr, 16'h0000);
        tick();
        check("first_valid", ir_valid, 1);
        check("first_data", ir_data, 16'h1234);
        check("first_pc", ir_pc, 16'h0001);
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            gap++;
            if (ir_valid) break;
        end
        check("stream_gap", gap, (EFF == 2) ? 1 : 2);
        check("second_data", ir_data, 16'h5678);
        check("second_pc", ir_pc, 16'h0002);

        // 2: consumer stalled, requests bounded by queue depth, then resume
        do_reset();
        repeat (10) tick();
        check("stall_reqs", req_count, EFF);
        check("stall_mem_req", mem_req, 0);
        check("stall_ir_valid", ir_valid, 1);
        ir_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (new_req) begin found = 1'b1; break; end
        end
        check("resume_found", found, 1);
        check("resume_addr", mem_addr, EFF);
        repeat (6) tick();
        check("stall_drained", (cons_count >= 2), 1);

        // 3: slow ack on addr 4 with redirect pending -> drained, then 0x3000
        do_reset();
        ir_ready      = 1'b1;
        special_en    = 1'b1;
        special_addr  = 16'h0004;
        special_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (new_req && mem_addr == 16'h0004) begin found = 1'b1; break; end
        end
        check("req4_found", found, 1);
        tick();
        redir_valid = 1'b1;
        redir_pc    = 16'h3000;
        tick();
        redir_valid = 1'b0;
        check("drain_req", mem_req, 1);
        check("drain_addr", mem_addr, 16'h0004);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (new_req) begin found = 1'b1; break; end
        end
        check("post_drain_found", found, 1);
        check("post_drain_addr", mem_addr, 16'h3000);
        for (int i = 0; i < 10; i++) begin
            if (ir_valid) break;
            tick();
        end
        check("post_drain_valid", ir_valid, 1);
        check("post_drain_data", ir_data, mem_word(16'h3000));

        // 4: redirect coinciding with ack on addr 7
        do_reset();
        ir_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (new_req && mem_addr == 16'h0007) begin found = 1'b1; break; end
        end
        check("req7_found", found, 1);
        redir_valid = 1'b1;
        redir_pc    = 16'h0010;
        tick();
        redir_valid = 1'b0;
        check("redir_ack_req", mem_req, 1);
        check("redir_ack_addr", mem_addr, 16'h0010);
        for (int i = 0; i < 10; i++) begin
            if (ir_valid) break;
            tick();
        end
        check("redir_ack_data", ir_data, mem_word(16'h0010));

        // 5: wrap-around at 0xFFFF
        do_reset();
        ir_ready    = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 16'hFFFF;
        tick();
        redir_valid = 1'b0;
        check("wrap_req_addr", mem_addr, 16'hFFFF);
        check("wrap_fetch_pc", fetch_pc, 16'h0000);
        got_req = 1'b0;
        got_ir  = 1'b0;
        req_addr_s = 16'h5555;
        ir_pc_s    = 16'h5555;
        ir_data_s  = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (new_req && !got_req) begin got_req = 1'b1; req_addr_s = mem_addr; end
            if (ir_valid && !got_ir) begin got_ir = 1'b1; ir_pc_s = ir_pc; ir_data_s = ir_data; end
            if (got_req && got_ir) break;
        end
        check("wrap_next_req", req_addr_s, 16'h0000);
        check("wrap_ir_pc", ir_pc_s, 16'h0000);
        check("wrap_ir_data", ir_data_s, mem_word(16'hFFFF));

        // 6: halt with a request outstanding; redirects ignored until reset
        do_reset();
        base_delay = 2;
        tick();
        check("halt_pre_req", mem_req, 1);
        halt      = 1'b1;
        ack_count = 0;
        tick();
        halt = 1'b0;
        repeat (3) tick();
        redir_valid = 1'b1;
        redir_pc    = 16'h0100;
        tick();
        redir_valid = 1'b0;
        repeat (6) tick();
        check("halt_acks", ack_count, 1);
        check("halt_mem_req", mem_req, 0);
        check("halt_valid", ir_valid, 0);
        check("halt_fetch_pc", fetch_pc, 16'h0001);
        check("halt_req_count", req_count, 1);
        base_delay = 0;
        do_reset();
        tick();
        check("post_halt_req", mem_req, 1);
        check("post_halt_addr", mem_addr, 16'h0000);

        // 7: randomized delays, back-pressure and redirects
        do_reset();
        rand_delay = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ir_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                redir_valid = 1'b1;
                redir_pc    = 16'($urandom);
            end else begin
                redir_valid = 1'b0;
            end
            tick();
        end
        redir_valid = 1'b0;
        rand_delay  = 1'b0;
        ir_ready    = 1'b1;
        c0 = cons_count;
        repeat (20) tick();
        check("random_live", (cons_count > c0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
